ft_nmr_monitor: RTL and testbench

- Parametrised N-core lockstep fault-tolerance monitor for the cevero FT cluster.
- Compares register-file writeback tuples {we, addr, data} from NCORES redundant cores and forwards agreed writes to the safe register file. Also holds a PC checkpoint and runs the core reset/recovery sequence.
- Adds optional majority voting, a recovery timeout with a sticky failure flag, and saturating error statistics.

---
 rtl/ft_nmr_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_ft_nmr_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_nmr_monitor.sv
// Purpose: N-core lockstep monitor; compares writeback tuples, forwards agreed writes, runs core recovery.
// Latency: register-file path and checkpoint are 1 cycle; FSM outputs decode the current state.
// Backpressure: none; writes are suppressed (rf_we_o=0) on unrecoverable errors and outside IDLE.
// Optional: define FT_MAJORITY_VOTE_EN to mask mismatches that have a strict-majority tuple.
module ft_nmr_monitor #(
  parameter int NCORES        = 3,
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int RST_CYCLES    = 4,
  parameter int TIMEOUT       = 1024,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [NCORES-1:0]            we_i,
  input  logic [NCORES*ADDR_WIDTH-1:0] addr_i,
  input  logic [NCORES*DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0]        pc_i,
  input  logic                         done_i,
  input  logic                         force_error_i,
  output logic                         rf_we_o,
  output logic [ADDR_WIDTH-1:0]        rf_addr_o,
  output logic [DATA_WIDTH-1:0]        rf_data_o,
  output logic [DATA_WIDTH-1:0]        pc_ckpt_o,
  output logic                         reset_cores_o,
  output logic                         recover_o,
  output logic                         recovering_o,
  output logic                         fail_o,
  output logic [NCORES-1:0]            faulty_core_o,
  output logic [ERR_CNT_WIDTH-1:0]     err_count_o
);

  localparam int TW      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESET   = 2'd1,
    ST_RECOVER = 2'd2,
    ST_FAIL    = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;

  logic [TW-1:0]     tup [NCORES];
  logic              agree;
  logic              idle;
  logic              err;
  logic              masked;
  logic              unrec;
  logic [TW-1:0]     sel_tup;
  logic [NCORES-1:0] dissent;

  // Unpack each core's {we, addr, data} tuple so they compare as single words.
  for (genvar k = 0; k < NCORES; k++) begin : g_tup
    assign tup[k] = {we_i[k], addr_i[k*ADDR_WIDTH +: ADDR_WIDTH], data_i[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  // Full agreement: every core's tuple equals core 0's, including addr/data when we=0.
  always_comb begin
    agree = 1'b1;
    for (int k = 1; k < NCORES; k++) begin
      if (tup[k] != tup[0]) agree = 1'b0;
    end
  end

  assign idle = (state == ST_IDLE);
  assign err  = enable_i && idle && (!agree || force_error_i);

`ifdef FT_MAJORITY_VOTE_EN
  logic          has_maj;
  logic [TW-1:0] maj_tup;

  // Find a tuple held by more than half of the cores and flag the cores that disagree with it.
  always_comb begin
    int votes;
    has_maj = 1'b0;
    maj_tup = tup[0];
    dissent = '0;
    for (int k = 0; k < NCORES; k++) begin
      votes = 0;
      for (int j = 0; j < NCORES; j++) begin
        if (tup[j] == tup[k]) votes = votes + 1;
      end
      if (!has_maj && (votes > NCORES / 2)) begin
        has_maj = 1'b1;
        maj_tup = tup[k];
      end
    end
    for (int k = 0; k < NCORES; k++) begin
      dissent[k] = has_maj && (tup[k] != maj_tup);
    end
  end

  // A forced error is never maskable; a genuine mismatch is masked when a majority exists.
  assign masked  = err && !force_error_i && has_maj;
  assign sel_tup = masked ? maj_tup : tup[0];
`else
  assign dissent = '0;
  assign masked  = 1'b0;
  assign sel_tup = tup[0];
`endif

  assign unrec = err && !masked;

  // Safe register-file port: one-cycle registered copy of the selected tuple, write gated to clean IDLE cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_we_o   <= 1'b0;
      rf_addr_o <= '0;
      rf_data_o <= '0;
    end else begin
      rf_we_o   <= idle && !unrec && sel_tup[TW-1];
      rf_addr_o <= sel_tup[DATA_WIDTH +: ADDR_WIDTH];
      rf_data_o <= sel_tup[DATA_WIDTH-1:0];
    end
  end

  // PC checkpoint follows the cores only while they are trusted (agreed or majority-corrected in IDLE).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_ckpt_o <= '0;
    end else if (idle && enable_i && (agree || masked)) begin
      pc_ckpt_o <= pc_i;
    end
  end

  // Saturating count of error cycles, masked or not.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_o <= '0;
    end else if (err && (err_count_o != '1)) begin
      err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
    end
  end

  // Sticky outvoted-core flags; a completed recovery resynchronises all cores and clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      faulty_core_o <= '0;
    end else if ((state == ST_RECOVER) && done_i) begin
      faulty_core_o <= '0;
    end else if (masked) begin
      faulty_core_o <= faulty_core_o | dissent;
    end
  end

  // Recovery FSM state and shared reset/timeout counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic: hold reset for RST_CYCLES, then wait up to TIMEOUT cycles for done_i.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (unrec) state_nx = ST_RESET;
      end
      ST_RESET: begin
        if (cnt == CNT_W'(RST_CYCLES - 1)) begin
          state_nx = ST_RECOVER;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (done_i) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx = ST_FAIL;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      ST_FAIL: begin
        cnt_nx = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign reset_cores_o = (state == ST_RESET) || (state == ST_FAIL);
  assign recover_o     = (state == ST_RECOVER);
  assign recovering_o  = !idle;
  assign fail_o        = (state == ST_FAIL);

endmodule

// File: tb/tb_ft_nmr_monitor.sv
// Directed bench for ft_nmr_monitor (NCORES=3, RST_CYCLES=4, TIMEOUT=16, ERR_CNT_WIDTH=2).
// Stimulus pushes the expected post-edge outputs tagged with a cycle number; a monitor pops and compares.
// Expectations branch on FT_MAJORITY_VOTE_EN where the two builds differ.
module tb_ft_nmr_monitor;

  localparam logic [3:0] C_IDLE = 4'b0000;  // {reset_cores, recover, recovering, fail}
  localparam logic [3:0] C_RST  = 4'b1010;
  localparam logic [3:0] C_REC  = 4'b0110;
  localparam logic [3:0] C_FL   = 4'b1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  we;
  logic [14:0] addr;
  logic [95:0] data;
  logic [31:0] pc;
  logic        done;
  logic        force_e;

  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pc_ckpt;
  logic        reset_cores;
  logic        recover;
  logic        recovering;
  logic        fail;
  logic [2:0]  faulty;
  logic [1:0]  err_cnt;

  ft_nmr_monitor #(
    .NCORES(3), .ADDR_WIDTH(5), .DATA_WIDTH(32),
    .RST_CYCLES(4), .TIMEOUT(16), .ERR_CNT_WIDTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .we_i(we), .addr_i(addr), .data_i(data), .pc_i(pc),
    .done_i(done), .force_error_i(force_e),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .pc_ckpt_o(pc_ckpt), .reset_cores_o(reset_cores), .recover_o(recover),
    .recovering_o(recovering), .fail_o(fail), .faulty_core_o(faulty),
    .err_count_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    string       nm;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
    logic [3:0]  ctl;
    logic [2:0]  f;
    logic [1:0]  e;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the entry expected for the current cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    logic [3:0] ctl;
    while (q.size() > 0 && q[0].tag < cyc) begin
      x = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", x.nm, x.tag, cyc);
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      x = q.pop_front();
      ctl = {reset_cores, recover, recovering, fail};
      checks++;
      if (rf_we !== x.we || rf_addr !== x.a || rf_data !== x.d || pc_ckpt !== x.pc ||
          ctl !== x.ctl || faulty !== x.f || err_cnt !== x.e) begin
        failures++;
        $display("FAIL %s cyc=%0d: got we=%b addr=%0d data=%h pc=%h ctl=%b faulty=%b err=%0d; want we=%b addr=%0d data=%h pc=%h ctl=%b faulty=%b err=%0d",
                 x.nm, cyc, rf_we, rf_addr, rf_data, pc_ckpt, ctl, faulty, err_cnt,
                 x.we, x.a, x.d, x.pc, x.ctl, x.f, x.e);
      end
    end
  end

  task automatic set_cores(input logic [2:0] w, input logic [4:0] a0, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2);
    we   = w;
    addr = {a2, a1, a0};
    data = {d2, d1, d0};
  endtask

  // Queue the outputs expected after the coming clock edge, then advance one cycle.
  task automatic step(input string nm, input logic xw, input logic [4:0] xa, input logic [31:0] xd,
                      input logic [31:0] xpc, input logic [3:0] xctl, input logic [2:0] xf,
                      input logic [1:0] xe);
    exp_t x;
    x.tag = cyc + 1;
    x.nm  = nm;
    x.we  = xw;
    x.a   = xa;
    x.d   = xd;
    x.pc  = xpc;
    x.ctl = xctl;
    x.f   = xf;
    x.e   = xe;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that entered RESET. Holds mismatching/forced inputs throughout
  // (they must be ignored), pulses done_i inside RESET (ignored), then asserts done_i on the
  // RECOVER cycle with index done_at.
  task automatic recover_flow(input int done_at, input logic [1:0] xe, input logic [31:0] xpc,
                              input logic [2:0] fdur);
    set_cores(3'b111, 5'd6, 5'd6, 5'd6, 32'h66, 32'h66, 32'h67);
    pc      = 32'h999;
    force_e = 1'b1;
    for (int i = 1; i < 4; i++) begin
      done = (i == 2);
      step("reset_hold", 1'b0, 5'd6, 32'h66, xpc, C_RST, fdur, xe);
    end
    done = 1'b0;
    step("enter_recover", 1'b0, 5'd6, 32'h66, xpc, C_REC, fdur, xe);
    for (int r = 0; r < done_at; r++) begin
      step("recover_wait", 1'b0, 5'd6, 32'h66, xpc, C_REC, fdur, xe);
    end
    done = 1'b1;
    step("recover_done", 1'b0, 5'd6, 32'h66, xpc, C_IDLE, 3'b000, xe);
    done    = 1'b0;
    force_e = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; done = 1'b0; force_e = 1'b0; pc = '0;
    set_cores(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    step("reset0", 1'b0, 5'd0, 32'h0, 32'h0, C_IDLE, 3'b000, 2'd0);
    step("reset1", 1'b0, 5'd0, 32'h0, 32'h0, C_IDLE, 3'b000, 2'd0);
    rst = 1'b0;

    // Agreed write.
    en = 1'b1; pc = 32'h100;
    set_cores(3'b111, 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    step("agreed_write", 1'b1, 5'd5, 32'hDEADBEEF, 32'h100, C_IDLE, 3'b000, 2'd0);

    // Comparison disabled: core 0 forwarded, no error, checkpoint held.
    en = 1'b0; pc = 32'h200;
    set_cores(3'b011, 5'd9, 5'd9, 5'd10, 32'h11, 32'h22, 32'h33);
    step("en0_fwd_a", 1'b1, 5'd9, 32'h11, 32'h100, C_IDLE, 3'b000, 2'd0);
    set_cores(3'b110, 5'd2, 5'd3, 5'd4, 32'hAA, 32'hBB, 32'hCC);
    step("en0_fwd_b", 1'b0, 5'd2, 32'hAA, 32'h100, C_IDLE, 3'b000, 2'd0);
    en = 1'b1;

`ifdef FT_MAJORITY_VOTE_EN
    // Core 1 outvoted on address, held 3 cycles: masked, stays IDLE, checkpoint follows.
    set_cores(3'b111, 5'd3, 5'd7, 5'd3, 32'h55, 32'h55, 32'h55);
    for (int i = 0; i < 3; i++) begin
      pc = 32'h300 + 32'(4 * i);
      step("masked_addr", 1'b1, 5'd3, 32'h55, pc, C_IDLE, 3'b010, 2'(i + 1));
    end
    // Core 2 outvoted on data; counter already saturated.
    set_cores(3'b111, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 32'h1);
    for (int i = 0; i < 2; i++) begin
      pc = 32'h310 + 32'(4 * i);
      step("masked_data", 1'b1, 5'd4, 32'h0, pc, C_IDLE, 3'b110, 2'd3);
    end
    // Three-way split: no majority, full recovery; done on the first RECOVER cycle clears flags.
    set_cores(3'b111, 5'd4, 5'd4, 5'd4, 32'h1, 32'h2, 32'h3);
    pc = 32'h320;
    step("no_majority", 1'b0, 5'd4, 32'h1, 32'h314, C_RST, 3'b110, 2'd3);
    recover_flow(0, 2'd3, 32'h314, 3'b110);
`else
    // Address mismatch: unrecoverable, done on third RECOVER cycle.
    set_cores(3'b111, 5'd3, 5'd7, 5'd3, 32'h55, 32'h55, 32'h55);
    pc = 32'h300;
    step("unrec_addr", 1'b0, 5'd3, 32'h55, 32'h100, C_RST, 3'b000, 2'd1);
    recover_flow(2, 2'd1, 32'h100, 3'b000);
    // Data mismatch on core 2.
    set_cores(3'b111, 5'd4, 5'd4, 5'd4, 32'h0, 32'h0, 32'h1);
    pc = 32'h310;
    step("unrec_data", 1'b0, 5'd4, 32'h0, 32'h100, C_RST, 3'b000, 2'd2);
    recover_flow(2, 2'd2, 32'h100, 3'b000);
    // Forced error with agreeing cores; checkpoint still taken; done on first RECOVER cycle.
    set_cores(3'b111, 5'd8, 5'd8, 5'd8, 32'h88, 32'h88, 32'h88);
    pc = 32'h320; force_e = 1'b1;
    step("force_agree", 1'b0, 5'd8, 32'h88, 32'h320, C_RST, 3'b000, 2'd3);
    recover_flow(0, 2'd3, 32'h320, 3'b000);
`endif

    // Back in IDLE with clean inputs.
    set_cores(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    pc = 32'h330;
    step("idle_after", 1'b0, 5'd0, 32'h0, 32'h330, C_IDLE, 3'b000, 2'd3);

    // Timeout: forced error, done never arrives -> FAIL after 4 + 16 cycles, sticky until reset.
    set_cores(3'b111, 5'd1, 5'd1, 5'd1, 32'h1234, 32'h1234, 32'h1234);
    pc = 32'h500; force_e = 1'b1;
    step("force_timeout", 1'b0, 5'd1, 32'h1234, 32'h500, C_RST, 3'b000, 2'd3);
    force_e = 1'b0;
    for (int i = 0; i < 3; i++) step("to_reset", 1'b0, 5'd1, 32'h1234, 32'h500, C_RST, 3'b000, 2'd3);
    for (int i = 0; i < 16; i++) step("to_recover", 1'b0, 5'd1, 32'h1234, 32'h500, C_REC, 3'b000, 2'd3);
    step("fail_set", 1'b0, 5'd1, 32'h1234, 32'h500, C_FL, 3'b000, 2'd3);
    done = 1'b1;
    for (int i = 0; i < 2; i++) step("fail_sticky", 1'b0, 5'd1, 32'h1234, 32'h500, C_FL, 3'b000, 2'd3);
    done = 1'b0;
    rst = 1'b1;
    step("rst_from_fail", 1'b0, 5'd0, 32'h0, 32'h0, C_IDLE, 3'b000, 2'd0);
    rst = 1'b0;

    // Reset asserted during RESET returns to IDLE with all outputs cleared.
    set_cores(3'b111, 5'd2, 5'd2, 5'd2, 32'h22, 32'h22, 32'h22);
    pc = 32'h600;
    step("post_rst_write", 1'b1, 5'd2, 32'h22, 32'h600, C_IDLE, 3'b000, 2'd0);
    force_e = 1'b1;
    step("force_again", 1'b0, 5'd2, 32'h22, 32'h600, C_RST, 3'b000, 2'd1);
    force_e = 1'b0;
    step("reset_mid", 1'b0, 5'd2, 32'h22, 32'h600, C_RST, 3'b000, 2'd1);
    rst = 1'b1;
    step("rst_mid", 1'b0, 5'd0, 32'h0, 32'h0, C_IDLE, 3'b000, 2'd0);
    rst = 1'b0;
    step("after_rst_mid", 1'b1, 5'd2, 32'h22, 32'h600, C_IDLE, 3'b000, 2'd0);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
